axi_sram_slave: RTL and testbench

AXI-style responder that terminates the fabric's combined-address-channel master port (shared read/write address channel, W channel, R channel, no B channel) and maps bursts onto a single-port 1024 x 64-bit synchronous SRAM. It sits on the far end of the fabric's DDR-side master port and serves as an on-chip memory target. It supports INCR, FIXED and WRAP bursts of 1 to 16 beats. Read data is buffered in a 2-entry FIFO so that `rready` back-pressure never stalls SRAM data in flight.

---
 rtl/axi_sram_slave.sv | 208 ++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// Combined-address-channel AXI responder onto a 1024 x 64 single-port synchronous SRAM.
// Supports FIXED/INCR/WRAP bursts of 1..16 beats and uses a 2-entry read FIFO to absorb rready stalls.
//
// state  | meaning
// IDLE   | aready high, waiting for an address
// WRITE  | accepting W beats, one SRAM write per beat
// READ   | issuing SRAM reads and draining the FIFO onto R
module axi_sram_slave #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32
) (
   input  logic              gclk,
   input  logic              gresetn,
   input  logic [ID_W-1:0]   aid,
   input  logic [ADDR_W-1:0] aaddr,
   input  logic              avalid,
   input  logic              awrite,
   input  logic [3:0]        alen,
   input  logic [2:0]        asize,
   input  logic [1:0]        aburst,
   output logic              aready,
   input  logic [ID_W-1:0]   wid,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [ID_W-1:0]   rid,
   output logic [63:0]       rdata,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   output logic              sram_cen,
   output logic [7:0]        sram_wen,
   output logic [9:0]        sram_addr,
   output logic [63:0]       sram_datain,
   input  logic [63:0]       sram_dataout,
   output logic              err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;

   logic [1:0]      state_q, state_d;
   logic            aready_q;
   logic [ID_W-1:0] id_q;
   logic [12:0]     addr_q;
   logic [3:0]      len_q;
   logic [1:0]      size_q;
   logic [1:0]      burst_q;
   logic [3:0]      cnt_q;
   logic [4:0]      icnt_q;
   logic            rd1_q, rd2_q, last1_q, last2_q;
   logic [63:0]     fifo_data_q [2];
   logic            fifo_last_q [2];
   logic            wptr_q, rptr_q;
   logic [1:0]      fcnt_q;
   logic            sram_cen_q;
   logic [7:0]      sram_wen_q;
   logic [9:0]      sram_addr_q;
   logic [63:0]     sram_datain_q;
   logic            err_q;

   logic            a_hs, w_hs, pop, issue_rd, wrap_ok, bad_size;
   logic [1:0]      acc_size, acc_burst;
   logic [2:0]      occ;
   logic            unused_bits;

   assign unused_bits = ^{wid, aaddr[ADDR_W-1:13]};

   // FIXED holds, WRAP stays inside a (len+1)<<size window, everything else increments.
   function automatic logic [12:0] next_addr(input logic [12:0] a, input logic [1:0] sz,
                                             input logic [3:0] ln, input logic [1:0] bt);
      logic [12:0] step, mask, sum;
      step = 13'd1 << sz;
      mask = (({9'd0, ln} + 13'd1) << sz) - 13'd1;
      sum  = a + step;
      case (bt)
         2'd0:    return a;
         2'd2:    return (a & ~mask) | (sum & mask);
         default: return sum;
      endcase
   endfunction

   assign a_hs      = avalid & aready_q;
   assign wready    = (state_q == S_WRITE);
   assign w_hs      = wvalid & wready;
   assign rvalid    = (fcnt_q != 2'd0);
   assign pop       = rvalid & rready;
   assign rdata     = rvalid ? fifo_data_q[rptr_q] : 64'd0;
   assign rid       = rvalid ? id_q : '0;
   assign rlast     = rvalid & fifo_last_q[rptr_q];

   assign wrap_ok   = (alen == 4'd1) || (alen == 4'd3) || (alen == 4'd7) || (alen == 4'd15);
   assign bad_size  = (asize > 3'd3);
   assign acc_size  = bad_size ? 2'd3 : asize[1:0];
   assign acc_burst = (aburst == 2'd2 && !wrap_ok) ? 2'd1 : aburst;

   // Reads in the SRAM pipeline plus FIFO entries must never exceed the two FIFO slots.
   assign occ      = {1'b0, fcnt_q} + {2'b0, rd1_q} + {2'b0, rd2_q};
   assign issue_rd = (state_q == S_READ) && (icnt_q <= {1'b0, len_q}) &&
                     (occ < (3'd2 + {2'b0, pop}));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (a_hs) state_d = awrite ? S_WRITE : S_READ;
         S_WRITE: if (w_hs && cnt_q == len_q) state_d = S_IDLE;
         S_READ:  if (pop && rlast) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge gclk) begin
      if (!gresetn) begin
         state_q       <= S_IDLE;
         aready_q      <= 1'b0;
         id_q          <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         size_q        <= '0;
         burst_q       <= '0;
         cnt_q         <= '0;
         icnt_q        <= '0;
         rd1_q         <= 1'b0;
         rd2_q         <= 1'b0;
         last1_q       <= 1'b0;
         last2_q       <= 1'b0;
         wptr_q        <= 1'b0;
         rptr_q        <= 1'b0;
         fcnt_q        <= '0;
         sram_cen_q    <= 1'b1;
         sram_wen_q    <= 8'hFF;
         sram_addr_q   <= '0;
         sram_datain_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q    <= state_d;
         aready_q   <= (state_d == S_IDLE);
         sram_cen_q <= 1'b1;
         sram_wen_q <= 8'hFF;
         rd1_q      <= 1'b0;
         rd2_q      <= rd1_q;
         last2_q    <= last1_q;

         if (a_hs) begin
            id_q    <= aid;
            len_q   <= alen;
            size_q  <= acc_size;
            burst_q <= acc_burst;
            cnt_q   <= '0;
            if (bad_size || (aburst == 2'd2 && !wrap_ok)) err_q <= 1'b1;
            if (awrite) begin
               addr_q <= aaddr[12:0];
               icnt_q <= '0;
            end else begin
               // First read beat is launched on acceptance so data lands in T+2.
               addr_q      <= next_addr(aaddr[12:0], acc_size, alen, acc_burst);
               icnt_q      <= 5'd1;
               sram_cen_q  <= 1'b0;
               sram_addr_q <= aaddr[12:3];
               rd1_q       <= 1'b1;
               last1_q     <= (alen == 4'd0);
            end
         end

         if (w_hs) begin
            sram_cen_q    <= 1'b0;
            sram_wen_q    <= ~wstrb;
            sram_addr_q   <= addr_q[12:3];
            sram_datain_q <= wdata;
            addr_q        <= next_addr(addr_q, size_q, len_q, burst_q);
            cnt_q         <= cnt_q + 4'd1;
            if (wlast != (cnt_q == len_q)) err_q <= 1'b1;
         end

         if (issue_rd) begin
            sram_cen_q  <= 1'b0;
            sram_addr_q <= addr_q[12:3];
            addr_q      <= next_addr(addr_q, size_q, len_q, burst_q);
            icnt_q      <= icnt_q + 5'd1;
            rd1_q       <= 1'b1;
            last1_q     <= (icnt_q[3:0] == len_q);
         end

         if (rd2_q) begin
            fifo_data_q[wptr_q] <= sram_dataout;
            fifo_last_q[wptr_q] <= last2_q;
            wptr_q              <= ~wptr_q;
         end
         if (pop) rptr_q <= ~rptr_q;
         case ({rd2_q, pop})
            2'b10:   fcnt_q <= fcnt_q + 2'd1;
            2'b01:   fcnt_q <= fcnt_q - 2'd1;
            default: fcnt_q <= fcnt_q;
         endcase
      end
   end

   assign aready      = aready_q;
   assign sram_cen    = sram_cen_q;
   assign sram_wen    = sram_wen_q;
   assign sram_addr   = sram_addr_q;
   assign sram_datain = sram_datain_q;
   assign err         = err_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural SRAM and an access log.
module tb_axi_sram_slave;

   logic        gclk = 1'b0;
   logic        gresetn = 1'b0;
   logic [3:0]  aid = '0;
   logic [31:0] aaddr = '0;
   logic        avalid = 1'b0, awrite = 1'b0;
   logic [3:0]  alen = '0;
   logic [2:0]  asize = '0;
   logic [1:0]  aburst = '0;
   logic        aready;
   logic [3:0]  wid = '0;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        wlast = 1'b0, wvalid = 1'b0;
   logic        wready;
   logic [3:0]  rid;
   logic [63:0] rdata;
   logic        rlast, rvalid;
   logic        rready = 1'b0;
   logic        sram_cen;
   logic [7:0]  sram_wen;
   logic [9:0]  sram_addr;
   logic [63:0] sram_datain;
   logic [63:0] sram_dataout = '0;
   logic        err;

   axi_sram_slave #(.ID_W(4), .ADDR_W(32)) dut (
      .gclk(gclk), .gresetn(gresetn),
      .aid(aid), .aaddr(aaddr), .avalid(avalid), .awrite(awrite),
      .alen(alen), .asize(asize), .aburst(aburst), .aready(aready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_datain(sram_datain), .sram_dataout(sram_dataout), .err(err)
   );

   always #5 gclk = ~gclk;

   int cyc = 0;
   always @(posedge gclk) cyc <= cyc + 1;

   logic [63:0] mem [0:1023];
   always @(posedge gclk) begin
      if (!sram_cen) begin
         if (sram_wen == 8'hFF) sram_dataout <= mem[sram_addr];
         else for (int b = 0; b < 8; b++)
            if (!sram_wen[b]) mem[sram_addr][8*b +: 8] = sram_datain[8*b +: 8];
      end
   end

   logic [9:0]  log_addr [$];
   logic [7:0]  log_wen  [$];
   logic [63:0] log_din  [$];
   int          log_cyc  [$];
   int          nrd = 0, npop = 0, max_out = 0, stall_bad = 0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data = '0;

   always @(negedge gclk) begin
      if (!gresetn) begin
         nrd = 0; npop = 0; prev_stall = 1'b0;
      end else begin
         if (!sram_cen) begin
            log_addr.push_back(sram_addr); log_wen.push_back(sram_wen);
            log_din.push_back(sram_datain); log_cyc.push_back(cyc);
            if (sram_wen == 8'hFF) nrd++;
         end
         if (nrd - npop > max_out) max_out = nrd - npop;
         if (prev_stall && (!rvalid || rdata !== prev_data)) stall_bad++;
         prev_stall = rvalid && !rready;
         prev_data  = rdata;
         if (rvalid && rready) npop++;
      end
   end

   int          n_chk = 0, n_fail = 0;
   int          acc_cyc, rd_first, rd_n;
   int          wbeat_cyc [16];
   logic [63:0] rd_data [16];
   logic [3:0]  rd_id   [16];
   logic        rd_last [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge gclk); #1;
   endtask

   task automatic clear_log();
      log_addr.delete(); log_wen.delete(); log_din.delete(); log_cyc.delete();
   endtask

   task automatic do_reset();
      gresetn = 1'b0; step(); step();
      gresetn = 1'b1; step();
   endtask

   task automatic issue_addr(input logic [3:0] id, input logic [31:0] addr, input logic wr,
                             input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
      bit ok;
      ok = 1'b0;
      aid = id; aaddr = addr; awrite = wr; alen = len; asize = size; aburst = burst; avalid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (aready) begin acc_cyc = cyc; ok = 1'b1; step(); break; end
         step();
      end
      avalid = 1'b0;
      chk("addr_accept", ok, 1);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [63:0] base,
                           input logic [7:0] strb, input int wlast_at);
      int nb;
      issue_addr(id, addr, 1'b1, len, size, burst);
      nb = 0;
      for (int k = 0; k < 100 && nb <= int'(len); k++) begin
         wvalid = 1'b1; wdata = base + 64'(nb); wstrb = strb; wlast = (nb == wlast_at);
         if (wready) begin wbeat_cyc[nb] = cyc; nb++; end
         step();
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("wr_beats", nb, 64'(len) + 1);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit bp,
                          input int abort_at);
      int nb, ph;
      bit done;
      issue_addr(id, addr, 1'b0, len, size, burst);
      nb = 0; ph = 0; done = 1'b0; rd_first = -1;
      for (int k = 0; k < 300 && !done; k++) begin
         rready = bp ? (ph == 0 || ph == 3) : 1'b1;
         ph = (ph + 1) % 4;
         if (rvalid && rd_first < 0) begin
            rd_first = cyc;
            chk("rd_wready_low", wready, 0);
         end
         if (rvalid && nb == abort_at) begin
            gresetn = 1'b0; rready = 1'b0; step();
            chk("abort_rvalid", rvalid, 0);
            chk("abort_cen", sram_cen, 1);
            step(); gresetn = 1'b1; step();
            done = 1'b1;
         end else begin
            if (rvalid && rready) begin
               rd_data[nb] = rdata; rd_id[nb] = rid; rd_last[nb] = rlast;
               nb++;
               if (rlast) done = 1'b1;
            end
            step();
         end
      end
      rready = 1'b0; rd_n = nb;
      chk("rd_complete", done, 1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);

      // reset values
      step(); step(); step();
      chk("rst_aready", aready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_r", {rvalid, rlast, rid}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_cen_wen", {sram_cen, sram_wen}, 9'h1FF);
      chk("rst_addr", sram_addr, 0);
      chk("rst_datain", sram_datain, 0);
      chk("rst_err", err, 0);
      gresetn = 1'b1; step();
      chk("rel_aready", aready, 1);

      // INCR write 0x100, 4 beats
      clear_log();
      do_write(4'd3, 32'h100, 4'd3, 3'd3, 2'd1, 64'hA0, 8'hFF, 3);
      chk("wr_aready_back", aready, 1);
      step();
      chk("wr_log_n", log_addr.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("wr_addr", log_addr[i], 10'h20 + 10'(i));
         chk("wr_data", log_din[i], 64'hA0 + 64'(i));
         chk("wr_wen", log_wen[i], 8'h00);
         chk("wr_lat", log_cyc[i] - wbeat_cyc[i], 1);
      end

      // INCR read back
      clear_log();
      do_read(4'd5, 32'h100, 4'd3, 3'd3, 2'd1, 1'b0, -1);
      chk("rd_aready_back", aready, 1);
      chk("rd_first_lat", rd_first - acc_cyc, 3);
      chk("rd_n", rd_n, 4);
      for (int i = 0; i < 4; i++) begin
         chk("rd_data", rd_data[i], 64'hA0 + 64'(i));
         chk("rd_id", rd_id[i], 4'd5);
         chk("rd_last", rd_last[i], i == 3);
      end

      // back-pressure, 16 beats, rready 1-0-0-1
      step(); max_out = 0; stall_bad = 0;
      do_read(4'd6, 32'h200, 4'd15, 3'd3, 2'd1, 1'b1, -1);
      chk("bp_n", rd_n, 16);
      for (int i = 0; i < 16; i++)
         chk("bp_data", rd_data[i], 64'hC0DE_0000_0000_0000 | 64'(10'h40 + 10'(i)));
      chk("bp_last", rd_last[15], 1);
      chk("bp_max_outstanding", max_out <= 2, 1);
      chk("bp_stall_stable", stall_bad, 0);

      // WRAP 4 beats at 0x118
      step(); clear_log();
      do_read(4'd7, 32'h118, 4'd3, 3'd3, 2'd2, 1'b0, -1);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_addr", log_addr[i], 10'h20 + 10'((3 + i) % 4));
         chk("wrap_data", rd_data[i], 64'hA0 + 64'((3 + i) % 4));
      end

      // FIXED 3 beats at 0x40
      step(); clear_log();
      do_read(4'd1, 32'h40, 4'd2, 3'd3, 2'd0, 1'b0, -1);
      chk("fixed_log_n", log_addr.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("fixed_addr", log_addr[i], 10'h08);
         chk("fixed_data", rd_data[i], 64'hC0DE_0000_0000_0008);
      end

      // INCR across word 1023
      step(); clear_log();
      do_write(4'd2, 32'h1FF8, 4'd1, 3'd3, 2'd1, 64'h11, 8'hFF, 1);
      step();
      chk("wrap1023_a0", log_addr[0], 10'h3FF);
      chk("wrap1023_a1", log_addr[1], 10'h000);

      // byte strobes
      clear_log();
      do_write(4'd0, 32'h300, 4'd0, 3'd3, 2'd1, 64'h1122_3344_5566_7788, 8'h0F, 0);
      step();
      chk("strb_wen", log_wen[0], 8'hF0);
      do_read(4'd0, 32'h300, 4'd0, 3'd3, 2'd1, 1'b0, -1);
      chk("strb_merge", rd_data[0], 64'hC0DE_0000_5566_7788);
      chk("no_err_yet", err, 0);

      // early wlast
      step(); clear_log();
      do_write(4'd0, 32'h400, 4'd3, 3'd3, 2'd1, 64'hB0, 8'hFF, 1);
      step();
      chk("wlast_err", err, 1);
      chk("wlast_beats", log_addr.size(), 4);
      do_reset();
      chk("err_cleared", err, 0);

      // oversize asize runs with 8-byte beats
      do_read(4'd9, 32'h100, 4'd1, 3'd4, 2'd1, 1'b0, -1);
      chk("asize_err", err, 1);
      chk("asize_d0", rd_data[0], 64'hA0);
      chk("asize_d1", rd_data[1], 64'hA1);
      do_reset();

      // reset during beat 2 of 8, then a fresh read
      do_read(4'd4, 32'h200, 4'd7, 3'd3, 2'd1, 1'b0, 2);
      chk("abort_aready", aready, 1);
      do_read(4'd4, 32'h200, 4'd1, 3'd3, 2'd1, 1'b0, -1);
      chk("post_rst_d0", rd_data[0], 64'hC0DE_0000_0000_0040);
      chk("post_rst_d1", rd_data[1], 64'hC0DE_0000_0000_0041);
      chk("post_rst_id", rd_id[0], 4'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
